divu_hilo_unit: RTL and testbench
=================================

Name: divu_hilo_unit

Overview:
- Multi-cycle unsigned divider with its own HI/LO register pair, located in the EX stage of the 5-stage pipeline.
- Consumes the 2-bit `signal` code produced by ALU control:
  - 00 = divu
  - 10 = mfhi
  - 01 = mflo
  - 11 = no HI/LO operation
- Runs a restoring division, one quotient bit per cycle.
- Returns HI/LO contents for mfhi/mflo.
- Raises `stall` so the pipeline holds any HI/LO instruction that arrives while a divide is still running.

Parameters:
- WIDTH, 32, operand, quotient, remainder and HI/LO width.
- CNT_W, 5, iteration counter width; must equal clog2(WIDTH).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- op_valid  input  1  EX stage holds a valid instruction; the pipeline keeps it high while the instruction is held.
- signal  input  2  HI/LO operation code: 00 divu, 10 mfhi, 01 mflo, 11 none.
- dividend  input  WIDTH  rs operand, used on divu issue.
- divisor  input  WIDTH  rt operand, used on divu issue.
- dataOut  output  WIDTH  HI (mfhi) or LO (mflo); 0 otherwise.
- stall  output  1  hold EX and earlier stages.
- busy  output  1  division in progress.
- done  output  1  one-cycle pulse after HI/LO are written.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, HI=0, LO=0, count=0, remainder/quotient working registers=0, busy=0, done=0. Combinational outputs follow from that state: stall=0, dataOut=0.
- States: IDLE, BUSY.
- Issue: an instruction is consumed on the first cycle it sees op_valid=1 with stall=0.
- IDLE, op_valid=1, signal=00 (divu issue), cycle T:
  - Latch dividend into the quotient shift register, divisor into the divisor register; clear the remainder; count=0; go to BUSY.
  - stall=0 in cycle T, so divu leaves EX without waiting.
- BUSY, one iteration per cycle:
  - {rem,quo} shifted left by 1.
  - If rem >= divisor: rem -= divisor and quotient LSB=1; else quotient LSB=0.
  - The compare uses a WIDTH+1-bit subtraction with no overflow.
  - Iterations run on cycles T+1..T+32. On the edge that ends T+32: LO=quotient, HI=remainder; state -> IDLE.
  - busy=1 on cycles T+1..T+32 exactly; done=1 on cycle T+33 only.
- Divide by zero: no special case. The algorithm yields LO=all ones and HI=dividend, with the normal 32-cycle latency.
- stall = (state==BUSY) && op_valid && (signal != 11). Non-HI/LO instructions proceed during a divide.
- dataOut (combinational, from current HI/LO):
  - signal=10 -> HI; signal=01 -> LO; else 0.
  - Valid whenever stall=0. HI/LO written on the last BUSY edge are visible in the following IDLE cycle, so no forwarding path is needed.
- divu arriving while BUSY: stalled, then issued in the first IDLE cycle (T+33), back-to-back with the previous divide.
- mfhi/mflo arriving while BUSY: stalled until T+33, then return the new HI/LO.
- op_valid=0 or signal=11: no state change.
- Reset mid-division: the divide is aborted, HI/LO are cleared, no done pulse.
- HI/LO change only at division completion or reset.

Optional Feature:
- Macro: DIVU_EARLY_OUT_EN.
- Defined: on divu issue, if divisor != 0 and dividend < divisor, the unit writes LO=0 and HI=dividend on the issue edge and stays in IDLE. busy is never raised; done pulses on cycle T+1.
- Undefined: every divu takes the full 32 BUSY cycles, including trivial cases.

Test Plan:
- Divide 100 by 7 issued at T: busy=1 for T+1..T+32, done at T+33; then mflo -> dataOut=14, mfhi -> dataOut=2.
- Divide 0x12345678 by 0: after 32 cycles LO=0xFFFFFFFF, HI=0x12345678.
- Divide 0xFFFFFFFF by 1, with mflo presented at T+5: stall=1 on T+5..T+32; at T+33 stall=0 and dataOut=0xFFFFFFFF. A non-HI/LO op (signal=11) at T+6 sees stall=0.
- Back-to-back divides, 50 by 5 then 9 by 4 (second presented at T+1): the second is stalled until T+33 and issued there; after its completion LO=2, HI=1.
- Assert rst for 1 cycle during iteration 10 of 1000 by 3: busy=0, HI=LO=0, no done pulse; a subsequent mfhi returns 0.
- Divide 5 by 9: with DIVU_EARLY_OUT_EN, done at T+1, busy never high, HI=5, LO=0; without it, done at T+33 with the same result.

Source files
------------

// File: rtl/divu_hilo_unit_if.sv
// Handshake and data bundle between the EX stage and the HI/LO divider.
// The master drives the instruction fields and the slave returns status and HI/LO data.
interface divu_hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [1:0]       signal;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] dataOut;
    logic             stall;
    logic             busy;
    logic             done;

    modport master (
        output op_valid, signal, dividend, divisor,
        input  dataOut, stall, busy, done
    );

    modport slave (
        input  op_valid, signal, dividend, divisor,
        output dataOut, stall, busy, done
    );
endinterface

// File: rtl/divu_hilo_unit.sv
// Restoring unsigned divider with HI/LO registers, one quotient bit per cycle.
// Optional macro DIVU_EARLY_OUT_EN: finish dividend<divisor divides on the issue edge.
module divu_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    divu_hilo_unit_if.slave  io_bus
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    logic             w_issue;
    logic             w_last;
    logic             w_early;
    logic             w_ge;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH+1:0] w_diff;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;

    assign w_issue = (r_state == S_IDLE) && io_bus.op_valid
                   && (io_bus.signal == 2'b00);
    assign w_last  = (r_state == S_BUSY)
                   && (r_cnt == CNT_W'(WIDTH - 1));

`ifdef DIVU_EARLY_OUT_EN
    assign w_early = w_issue && (io_bus.divisor != '0)
                   && (io_bus.dividend < io_bus.divisor);
`else
    assign w_early = 1'b0;
`endif

    // Shifted remainder is WIDTH+1 bits; a non-negative difference that fits
    // in WIDTH bits means the subtract step succeeds.
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_div};
    assign w_ge     = (w_diff[WIDTH+1:WIDTH] == 2'b00);
    assign w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_issue && !w_early) begin
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_issue) begin
                if (w_early) begin
                    r_lo   <= '0;
                    r_hi   <= io_bus.dividend;
                    r_done <= 1'b1;
                end else begin
                    r_quo <= io_bus.dividend;
                    r_div <= io_bus.divisor;
                    r_rem <= '0;
                    r_cnt <= '0;
                end
            end else if (r_state == S_BUSY) begin
                r_rem <= w_rem_nx;
                r_quo <= w_quo_nx;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_lo   <= w_quo_nx;
                    r_hi   <= w_rem_nx;
                    r_done <= 1'b1;
                end
            end
        end
    end

    // Only HI/LO ops wait; other instructions flow past a running divide.
    assign io_bus.stall = (r_state == S_BUSY) && io_bus.op_valid
                        && (io_bus.signal != 2'b11);
    assign io_bus.busy  = (r_state == S_BUSY);
    assign io_bus.done  = r_done;

    always_comb begin
        io_bus.dataOut = '0;
        case (io_bus.signal)
            2'b10:   io_bus.dataOut = r_hi;
            2'b01:   io_bus.dataOut = r_lo;
            default: io_bus.dataOut = '0;
        endcase
    end
endmodule

// File: tb/tb_divu_hilo_unit.sv
// Directed testbench for divu_hilo_unit: latency, stall, back-to-back,
// divide-by-zero, reset abort and the trivial dividend<divisor case.
module tb_divu_hilo_unit;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    divu_hilo_unit_if #(.WIDTH(32)) bus ();

    divu_hilo_unit #(
        .WIDTH (32),
        .CNT_W (5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus.slave)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.op_valid = 1'b0;
        bus.signal   = 2'b11;
        bus.dividend = '0;
        bus.divisor  = '0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        bus.op_valid = 1'b1;
        bus.signal   = 2'b00;
        bus.dividend = a;
        bus.divisor  = b;
        cyc();
        idle_in();
    endtask

    task automatic test_reset();
        idle_in();
        rst = 1'b1;
        #2;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: busy=%b done=%b expected 0 0",
                     bus.busy, bus.done);
        end
        bus.op_valid = 1'b1;
        bus.signal   = 2'b10;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.dataOut !== 32'h0) begin
            failures++;
            $display("FAIL reset_mfhi: stall=%b data=%h expected 0 0",
                     bus.stall, bus.dataOut);
        end
        idle_in();
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_divu_basic();
        bus.op_valid = 1'b1;
        bus.signal   = 2'b00;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL issue_stall: got %b expected 0", bus.stall);
        end
        cyc();
        idle_in();
        for (int k = 1; k <= 32; k++) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                failures++;
                $display("FAIL busy_window T+%0d: busy=%b done=%b expected 1 0",
                         k, bus.busy, bus.done);
            end
            cyc();
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL done_T33: busy=%b done=%b expected 0 1",
                     bus.busy, bus.done);
        end
        bus.op_valid = 1'b1;
        bus.signal   = 2'b01;
        #1;
        checks++;
        if (bus.dataOut !== 32'd14) begin
            failures++;
            $display("FAIL mflo_100_7: got %0d expected 14", bus.dataOut);
        end
        bus.signal = 2'b10;
        #1;
        checks++;
        if (bus.dataOut !== 32'd2) begin
            failures++;
            $display("FAIL mfhi_100_7: got %0d expected 2", bus.dataOut);
        end
        idle_in();
        cyc();
    endtask

    task automatic test_div_zero();
        issue(32'h1234_5678, 32'h0);
        repeat (32) cyc();
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL div0_done: got %b expected 1", bus.done);
        end
        bus.op_valid = 1'b1;
        bus.signal   = 2'b01;
        #1;
        checks++;
        if (bus.dataOut !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL div0_lo: got %h expected ffffffff", bus.dataOut);
        end
        bus.signal = 2'b10;
        #1;
        checks++;
        if (bus.dataOut !== 32'h1234_5678) begin
            failures++;
            $display("FAIL div0_hi: got %h expected 12345678", bus.dataOut);
        end
        idle_in();
        cyc();
    endtask

    task automatic test_stall();
        issue(32'hFFFF_FFFF, 32'd1);
        repeat (4) cyc();
        bus.op_valid = 1'b1;
        bus.signal   = 2'b01;
        for (int k = 5; k <= 32; k++) begin
            #1;
            checks++;
            if (bus.stall !== 1'b1) begin
                failures++;
                $display("FAIL mflo_stall T+%0d: got %b expected 1",
                         k, bus.stall);
            end
            if (k == 6) begin
                bus.signal = 2'b11;
                #1;
                checks++;
                if (bus.stall !== 1'b0) begin
                    failures++;
                    $display("FAIL nonhilo_stall: got %b expected 0",
                             bus.stall);
                end
                bus.signal = 2'b01;
            end
            cyc();
        end
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.dataOut !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL mflo_T33: stall=%b data=%h expected 0 ffffffff",
                     bus.stall, bus.dataOut);
        end
        idle_in();
        cyc();
    endtask

    task automatic test_back_to_back();
        bus.op_valid = 1'b1;
        bus.signal   = 2'b00;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
        cyc();
        bus.dividend = 32'd9;
        bus.divisor  = 32'd4;
        for (int k = 1; k <= 32; k++) begin
            #1;
            checks++;
            if (bus.stall !== 1'b1) begin
                failures++;
                $display("FAIL b2b_stall T+%0d: got %b expected 1",
                         k, bus.stall);
            end
            cyc();
        end
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_T33: stall=%b done=%b expected 0 1",
                     bus.stall, bus.done);
        end
        cyc();
        idle_in();
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_busy: got %b expected 1", bus.busy);
        end
        repeat (32) cyc();
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_done: got %b expected 1", bus.done);
        end
        bus.op_valid = 1'b1;
        bus.signal   = 2'b01;
        #1;
        checks++;
        if (bus.dataOut !== 32'd2) begin
            failures++;
            $display("FAIL b2b_lo: got %0d expected 2", bus.dataOut);
        end
        bus.signal = 2'b10;
        #1;
        checks++;
        if (bus.dataOut !== 32'd1) begin
            failures++;
            $display("FAIL b2b_hi: got %0d expected 1", bus.dataOut);
        end
        idle_in();
        cyc();
    endtask

    task automatic test_reset_mid();
        logic seen;
        seen = 1'b0;
        issue(32'd1000, 32'd3);
        repeat (9) cyc();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_busy: got %b expected 0", bus.busy);
        end
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
            cyc();
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done: got %b expected 0", seen);
        end
        bus.op_valid = 1'b1;
        bus.signal   = 2'b10;
        #1;
        checks++;
        if (bus.dataOut !== 32'h0) begin
            failures++;
            $display("FAIL abort_hi: got %h expected 0", bus.dataOut);
        end
        bus.signal = 2'b01;
        #1;
        checks++;
        if (bus.dataOut !== 32'h0) begin
            failures++;
            $display("FAIL abort_lo: got %h expected 0", bus.dataOut);
        end
        idle_in();
        cyc();
    endtask

    task automatic test_early();
        issue(32'd5, 32'd9);
`ifdef DIVU_EARLY_OUT_EN
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL early_T1: busy=%b done=%b expected 0 1",
                     bus.busy, bus.done);
        end
`else
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL trivial_busy: got %b expected 1", bus.busy);
        end
        repeat (32) cyc();
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL trivial_done: got %b expected 1", bus.done);
        end
`endif
        bus.op_valid = 1'b1;
        bus.signal   = 2'b10;
        #1;
        checks++;
        if (bus.dataOut !== 32'd5) begin
            failures++;
            $display("FAIL small_hi: got %0d expected 5", bus.dataOut);
        end
        bus.signal = 2'b01;
        #1;
        checks++;
        if (bus.dataOut !== 32'd0) begin
            failures++;
            $display("FAIL small_lo: got %0d expected 0", bus.dataOut);
        end
        idle_in();
        cyc();
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_div_zero();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_early();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
